// File: rtl/pe_array_scheduler.sv
// pe_array_scheduler: sequences C = A*B over an array of NUM_PE dot-product PEs.
// Walks rows of A and groups of NUM_PE columns of B. Each (row, group) pair
// streams K operand pairs into the PE input FIFOs. It then drains one result
// per active lane into C memory.
module pe_array_scheduler #(
  parameter int NUM_PE = 4,
  parameter int MAX_K  = 16,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DIM_W-1:0]       dim_m,
  input  logic [DIM_W-1:0]       dim_k,
  input  logic [DIM_W-1:0]       dim_n,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [ADDR_W-1:0]      a_addr,
  input  logic [31:0]            a_rdata,
  output logic [ADDR_W-1:0]      b_addr,
  input  logic [32*NUM_PE-1:0]   b_rdata,
  output logic                   c_we,
  output logic [ADDR_W-1:0]      c_addr,
  output logic [31:0]            c_wdata,
  output logic [NUM_PE-1:0]      pe_read_in,
  output logic [31:0]            pe_left,
  output logic [32*NUM_PE-1:0]   pe_right,
  output logic [31:0]            pe_length,
  output logic [NUM_PE-1:0]      pe_read_out,
  input  logic [NUM_PE-1:0]      pe_out_empty,
  input  logic [32*NUM_PE-1:0]   pe_output
);

  localparam int FLUSH_LEN = 2 * MAX_K + 8;
  localparam int FC_W      = $clog2(FLUSH_LEN + 1);
  localparam int LANE_W    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  typedef enum logic [2:0] {
    S_FLUSH, S_IDLE, S_FEED, S_WAIT, S_DRAIN, S_NEXT, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [FC_W-1:0]   flush_cnt;
  logic              vld_p1;
  logic [DIM_W-1:0]  m_dim, k_dim, n_dim;
  logic [ADDR_W-1:0] b_stride;
  logic [DIM_W-1:0]  i_cnt, k_cnt;
  logic [DIM_W:0]    col_base;
  logic [ADDR_W-1:0] g_idx;
  logic [ADDR_W-1:0] a_base, c_base;
  logic [LANE_W-1:0] lane;

  logic              dims_bad, last_k, last_row, last_grp, lane_last, all_ready;
  logic [NUM_PE-1:0] act_mask;
  logic [ADDR_W-1:0] k_step, n_step;

  // Number of column groups: ceil(n / NUM_PE), used as the B address stride per k
  function automatic logic [ADDR_W-1:0] groups_of(input logic [DIM_W-1:0] n);
    logic [DIM_W:0] s;
    s = {1'b0, n} + (DIM_W+1)'(NUM_PE - 1);
    return ADDR_W'(s / (DIM_W+1)'(NUM_PE));
  endfunction

  // Decode of dimension legality, loop ends and the active-lane mask of the current group
  always_comb begin
    dims_bad  = (dim_k == '0) || (dim_m == '0) || (dim_n == '0) ||
                (32'(dim_k) > 32'(MAX_K));
    last_k    = (k_cnt == k_dim - DIM_W'(1));
    last_row  = (i_cnt == m_dim - DIM_W'(1));
    last_grp  = (col_base + (DIM_W+1)'(NUM_PE)) >= {1'b0, n_dim};
    lane_last = (lane == LANE_W'(NUM_PE - 1)) ||
                ((col_base + (DIM_W+1)'(lane) + (DIM_W+1)'(1)) >= {1'b0, n_dim});
    k_step    = ADDR_W'(k_dim);
    n_step    = ADDR_W'(n_dim);
    act_mask  = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      act_mask[p] = (col_base + (DIM_W+1)'(p)) < {1'b0, n_dim};
    end
    // Wait for the final push to land before trusting the empty flags
    all_ready = (((~pe_out_empty) & act_mask) == act_mask) && !vld_p1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FLUSH;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_FLUSH: if (flush_cnt == FC_W'(FLUSH_LEN - 1)) state_nx = S_IDLE;
      S_IDLE:  if (start && !dims_bad) state_nx = S_FEED;
      S_FEED:  if (last_k) state_nx = S_WAIT;
      S_WAIT:  if (all_ready) state_nx = S_DRAIN;
      S_DRAIN: if (lane_last) state_nx = S_NEXT;
      S_NEXT:  state_nx = (last_grp && last_row) ? S_DONE : S_FEED;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_FLUSH;
    endcase
  end

  // Control registers: flush timer, push valid, sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= '0;
      vld_p1    <= 1'b0;
      err       <= 1'b0;
    end else begin
      flush_cnt <= (state == S_FLUSH) ? flush_cnt + FC_W'(1) : '0;
      vld_p1    <= (state == S_FEED);
      if (state == S_IDLE && start) err <= dims_bad;
    end
  end

  // Address walkers, loop counters and latched dimensions
  always_ff @(posedge clk) begin
    if (rst) begin
      a_addr    <= '0;
      b_addr    <= '0;
      pe_length <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start && !dims_bad) begin
          m_dim     <= dim_m;
          k_dim     <= dim_k;
          n_dim     <= dim_n;
          b_stride  <= groups_of(dim_n);
          pe_length <= 32'(dim_k);
          i_cnt     <= '0;
          k_cnt     <= '0;
          col_base  <= '0;
          g_idx     <= '0;
          a_base    <= '0;
          c_base    <= '0;
          a_addr    <= '0;
          b_addr    <= '0;
          lane      <= '0;
        end
        S_FEED: begin
          if (last_k) begin
            k_cnt <= '0;
          end else begin
            k_cnt  <= k_cnt + DIM_W'(1);
            a_addr <= a_addr + ADDR_W'(1);
            b_addr <= b_addr + b_stride;
          end
        end
        S_DRAIN: lane <= lane_last ? '0 : lane + LANE_W'(1);
        S_NEXT: begin
          if (last_grp) begin
            col_base <= '0;
            g_idx    <= '0;
            i_cnt    <= i_cnt + DIM_W'(1);
            a_base   <= a_base + k_step;
            c_base   <= c_base + n_step;
            a_addr   <= a_base + k_step;
            b_addr   <= '0;
          end else begin
            col_base <= col_base + (DIM_W+1)'(NUM_PE);
            g_idx    <= g_idx + ADDR_W'(1);
            a_addr   <= a_base;
            b_addr   <= g_idx + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: push stage p1 carries memory read data; drain/flush drive pops
  always_comb begin
    busy        = (state == S_FEED) || (state == S_WAIT) ||
                  (state == S_DRAIN) || (state == S_NEXT);
    done        = (state == S_DONE);
    c_we        = 1'b0;
    c_addr      = '0;
    c_wdata     = '0;
    pe_read_out = '0;
    pe_read_in  = vld_p1 ? act_mask : '0;
    pe_left     = vld_p1 ? a_rdata : '0;
    pe_right    = vld_p1 ? b_rdata : '0;
    if (state == S_DRAIN) begin
      c_we        = 1'b1;
      c_addr      = c_base + ADDR_W'(col_base) + ADDR_W'(lane);
      c_wdata     = pe_output[32*lane +: 32];
      pe_read_out = NUM_PE'(1) << lane;
    end else if (state == S_FLUSH && flush_cnt != '0) begin
      // First flush cycle is quiet so every output reads zero right after reset
      pe_read_out = ~pe_out_empty;
    end
  end

endmodule
